dma_nested_counter: RTL and testbench

Multi-level nested address generator for the DMA engine: walks up to `LEVELS` nested loops with per-level runtime wrap counts and address strides, and emits one address per beat on a valid/ready stream. It replaces chains of single-level step counters in the DMA read/write channels, producing the linear address directly. It also produces per-level loop-boundary flags and a completion pulse.

---
 rtl/dma_nested_counter.sv | 153 +++++++++++++++
 tb/tb_dma_nested_counter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_nested_counter.sv
// Multi-level nested address generator: walks LEVELS nested loops (level 0 innermost) and
// streams one linear address per accepted beat. Optional multi-pass mode: DMA_NESTED_COUNTER_REPEAT_EN.
module dma_nested_counter #(
  parameter int LEVELS   = 3,
  parameter int CNT_W    = 12,
  parameter int STRIDE_W = 16,
  parameter int ADDR_W   = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [ADDR_W-1:0]            base_i,
  input  logic [LEVELS*CNT_W-1:0]      wrap_i,
  input  logic [LEVELS*STRIDE_W-1:0]   stride_i,
`ifdef DMA_NESTED_COUNTER_REPEAT_EN
  input  logic                         repeat_i,
`endif
  output logic                         busy_o,
  output logic                         addr_valid_o,
  input  logic                         addr_ready_i,
  output logic [ADDR_W-1:0]            addr_o,
  output logic [LEVELS*CNT_W-1:0]      idx_o,
  output logic [LEVELS-1:0]            last_o,
  output logic                         done_o
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                             state_q, state_d;
  logic [LEVELS-1:0][CNT_W-1:0]       wrap_q;
  logic [LEVELS-1:0][STRIDE_W-1:0]    stride_q;
  logic [LEVELS-1:0][CNT_W-1:0]       idx_q, idx_d;
  logic [LEVELS-1:0][ADDR_W-1:0]      lvl_base_q, lvl_base_d;
  logic [ADDR_W-1:0]                  addr_q, addr_d, step_addr;
  logic                               done_q, done_d;
  logic                               cfg_load, run, xfer, found, lower;
  logic [LEVELS-1:0]                  at_wrap, sel, below, all_low;

`ifdef DMA_NESTED_COUNTER_REPEAT_EN
  logic                               repeat_q;
  logic [ADDR_W-1:0]                  rpt_base_q;

  always_ff @(posedge clk_i) begin
    if (cfg_load) begin
      repeat_q   <= repeat_i;
      rpt_base_q <= base_i;
    end
  end
`endif

  // Walk configuration only changes on a start, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (cfg_load) begin
      wrap_q   <= wrap_i;
      stride_q <= stride_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lvl_base_q <= '0;
      addr_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lvl_base_q <= lvl_base_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
    end
  end

  assign run  = (state_q == RUN);
  assign xfer = run && addr_ready_i;

  // sel is one-hot on the lowest level not at its wrap; below marks the levels under it.
  always_comb begin
    lower     = 1'b1;
    at_wrap   = '0;
    sel       = '0;
    below     = '0;
    all_low   = '0;
    step_addr = '0;
    for (int k = 0; k < LEVELS; k++) begin
      at_wrap[k] = (idx_q[k] == wrap_q[k]);
      sel[k]     = lower && !at_wrap[k];
      below[k]   = lower && at_wrap[k];
      lower      = lower && at_wrap[k];
      all_low[k] = lower;
      if (sel[k]) step_addr = lvl_base_q[k] + ADDR_W'(stride_q[k]);
    end
    found = |sel;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lvl_base_d = lvl_base_q;
    addr_d     = addr_q;
    done_d     = 1'b0;
    cfg_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d  = RUN;
          cfg_load = 1'b1;
          idx_d    = '0;
          addr_d   = base_i;
          for (int k = 0; k < LEVELS; k++) lvl_base_d[k] = base_i;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (xfer) begin
          if (found) begin
            addr_d = step_addr;
            for (int k = 0; k < LEVELS; k++) begin
              if (below[k]) idx_d[k] = '0;
              if (sel[k])   idx_d[k] = idx_q[k] + CNT_W'(1);
              if (below[k] || sel[k]) lvl_base_d[k] = step_addr;
            end
          end else begin
            done_d = 1'b1;
`ifdef DMA_NESTED_COUNTER_REPEAT_EN
            if (repeat_q) begin
              idx_d  = '0;
              addr_d = rpt_base_q;
              for (int k = 0; k < LEVELS; k++) lvl_base_d[k] = rpt_base_q;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o       = run;
  assign addr_valid_o = run;
  assign addr_o       = addr_q;
  assign idx_o        = idx_q;
  assign last_o       = all_low & {LEVELS{run}};
  assign done_o       = done_q;

endmodule

// File: tb/tb_dma_nested_counter.sv
// Directed bench for dma_nested_counter (LEVELS=3); repeat-mode scenario is built only
// when DMA_NESTED_COUNTER_REPEAT_EN is defined.
module tb_dma_nested_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [31:0] base = '0;
  logic [35:0] wrap = '0;
  logic [47:0] stride = '0;
  logic        busy, valid, done;
  logic [31:0] addr;
  logic [35:0] idx;
  logic [2:0]  last;
`ifdef DMA_NESTED_COUNTER_REPEAT_EN
  logic        rpt = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_addr [6] = '{32'h100, 32'h104, 32'h108, 32'h140, 32'h144, 32'h148};
  logic [2:0]  exp_last [6] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b111};
  logic [35:0] exp_idx  [6] = '{36'h000_000_000, 36'h000_000_001, 36'h000_000_002,
                                36'h000_001_000, 36'h000_001_001, 36'h000_001_002};

  always #5 clk = ~clk;

  dma_nested_counter #(.LEVELS(3), .CNT_W(12), .STRIDE_W(16), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .base_i(base), .wrap_i(wrap), .stride_i(stride),
`ifdef DMA_NESTED_COUNTER_REPEAT_EN
    .repeat_i(rpt),
`endif
    .busy_o(busy), .addr_valid_o(valid), .addr_ready_i(ready),
    .addr_o(addr), .idx_o(idx), .last_o(last), .done_o(done)
  );

  task automatic set_cfg(input logic [31:0] b, input logic [11:0] w0, w1, w2,
                         input logic [15:0] s0, s1, s2);
    base   = b;
    wrap   = {w2, w1, w0};
    stride = {s2, s1, s0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", valid); else n_pass++;
    n_checks++; if (addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", addr); else n_pass++;
    n_checks++; if (idx !== 36'h0) $display("FAIL rst_idx got %h exp 0", idx); else n_pass++;
    n_checks++; if (last !== 3'b000) $display("FAIL rst_last got %b exp 000", last); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_rel_busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_basic();
    set_cfg(32'h100, 12'd2, 12'd1, 12'd0, 16'h4, 16'h40, 16'h1000);
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", busy); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (addr !== exp_addr[i]) $display("FAIL basic_addr%0d got %h exp %h", i, addr, exp_addr[i]); else n_pass++;
      n_checks++; if (last !== exp_last[i]) $display("FAIL basic_last%0d got %b exp %b", i, last, exp_last[i]); else n_pass++;
      n_checks++; if (idx !== exp_idx[i]) $display("FAIL basic_idx%0d got %h exp %h", i, idx, exp_idx[i]); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL basic_early_done%0d got %b exp 0", i, done); else n_pass++;
      if (i < 5) @(negedge clk);
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL basic_done got %b exp 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL basic_idle got busy=%b valid=%b exp 0/0", busy, valid); else n_pass++;
    n_checks++; if (last !== 3'b000) $display("FAIL basic_idle_last got %b exp 000", last); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", done); else n_pass++;
  endtask

  task automatic test_backpressure();
    int nb = 0;
    bit fin = 1'b0;
    set_cfg(32'h100, 12'd2, 12'd1, 12'd0, 16'h4, 16'h40, 16'h1000);
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !fin; c++) begin
      ready = !(c >= 1 && c <= 3);
      if (done) begin
        fin = 1'b1;
      end else if (valid) begin
        if (!ready) begin
          n_checks++; if (addr !== 32'h104) $display("FAIL bp_hold_addr c%0d got %h exp 104", c, addr); else n_pass++;
          n_checks++; if (idx !== 36'h000_000_001) $display("FAIL bp_hold_idx c%0d got %h exp 000000001", c, idx); else n_pass++;
        end else if (nb < 6) begin
          n_checks++; if (addr !== exp_addr[nb]) $display("FAIL bp_addr%0d got %h exp %h", nb, addr, exp_addr[nb]); else n_pass++;
          nb++;
        end else begin
          n_checks++; $display("FAIL bp_extra_beat got %h exp none", addr);
        end
      end
      if (!fin) @(negedge clk);
    end
    ready = 1'b1;
    n_checks++; if (nb !== 6) $display("FAIL bp_beats got %0d exp 6", nb); else n_pass++;
    n_checks++; if (fin !== 1'b1) $display("FAIL bp_done_seen got %b exp 1", fin); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_degenerate();
    set_cfg(32'h2000, 12'd0, 12'd0, 12'd0, 16'h4, 16'h40, 16'h1000);
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (valid !== 1'b1 || addr !== 32'h2000) $display("FAIL deg_beat got valid=%b addr=%h exp 1/2000", valid, addr); else n_pass++;
    n_checks++; if (last !== 3'b111) $display("FAIL deg_last got %b exp 111", last); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL deg_done got %b exp 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL deg_busy got %b exp 0", busy); else n_pass++;
    base  = 32'h3000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (valid !== 1'b1 || addr !== 32'h3000) $display("FAIL deg_restart got valid=%b addr=%h exp 1/3000", valid, addr); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL deg_restart_done got %b exp 0", done); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL deg_done2 got %b exp 1", done); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_addr_wrap();
    set_cfg(32'hFFFF_FFFC, 12'd1, 12'd0, 12'd0, 16'h4, 16'h0, 16'h0);
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0 got %h exp fffffffc", addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (addr !== 32'h0000_0000) $display("FAIL wrap_addr1 got %h exp 00000000", addr); else n_pass++;
    n_checks++; if (last !== 3'b111) $display("FAIL wrap_last got %b exp 111", last); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL wrap_done got %b exp 1", done); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    set_cfg(32'h100, 12'd2, 12'd1, 12'd0, 16'h4, 16'h40, 16'h1000);
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (addr !== 32'h140) $display("FAIL abort_beat4 got %h exp 140", addr); else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL abort_idle got busy=%b valid=%b exp 0/0", busy, valid); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL abort_done got %b exp 0", done); else n_pass++;
    n_checks++; if (last !== 3'b000) $display("FAIL abort_last got %b exp 000", last); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL abort_done_late got %b exp 0", done); else n_pass++;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL start_abort_idle got busy=%b valid=%b exp 0/0", busy, valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    set_cfg(32'h100, 12'd2, 12'd1, 12'd0, 16'h4, 16'h40, 16'h1000);
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (addr !== 32'h104) $display("FAIL areset_pre_addr got %h exp 104", addr); else n_pass++;
    ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (addr !== 32'h0 || idx !== 36'h0) $display("FAIL areset_data got addr=%h idx=%h exp 0/0", addr, idx); else n_pass++;
    n_checks++; if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL areset_ctrl got busy=%b valid=%b exp 0/0", busy, valid); else n_pass++;
    n_checks++; if (last !== 3'b000 || done !== 1'b0) $display("FAIL areset_flags got last=%b done=%b exp 000/0", last, done); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL areset_after got busy=%b done=%b exp 0/0", busy, done); else n_pass++;
  endtask

`ifdef DMA_NESTED_COUNTER_REPEAT_EN
  task automatic test_repeat();
    set_cfg(32'h100, 12'd2, 12'd1, 12'd0, 16'h4, 16'h40, 16'h1000);
    ready = 1'b1;
    rpt   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rpt   = 1'b0;
    for (int c = 0; c < 13; c++) begin
      n_checks++; if (valid !== 1'b1 || addr !== exp_addr[c % 6]) $display("FAIL rpt_addr c%0d got valid=%b addr=%h exp 1/%h", c, valid, addr, exp_addr[c % 6]); else n_pass++;
      n_checks++; if (done !== (c > 0 && c % 6 == 0)) $display("FAIL rpt_done c%0d got %b exp %b", c, done, (c > 0 && c % 6 == 0)); else n_pass++;
      if (c < 12) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rpt_abort got busy=%b done=%b exp 0/0", busy, done); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_degenerate();
    test_addr_wrap();
    test_abort();
    test_async_reset();
`ifdef DMA_NESTED_COUNTER_REPEAT_EN
    test_repeat();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
